// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one asynchronous SRAM bank between the instruction-fetch
// master and the load/store master. Each transfer runs IDLE -> ACCESS -> ACK. Every
// SRAM control output and every ack comes straight from a register.
module sram_bus_arbiter #(
   parameter int ADDR_W        = 20,
   parameter int DATA_W        = 32,
   parameter int WAIT_CYCLES   = 1,
   parameter int DATA_PRIORITY = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req_i,
   input  logic [ADDR_W-1:0]   inst_addr_i,
   output logic [DATA_W-1:0]   inst_rdata_o,
   output logic                inst_ack_o,
   input  logic                data_req_i,
   input  logic                data_we_i,
   input  logic [ADDR_W-1:0]   data_addr_i,
   input  logic [DATA_W/8-1:0] data_be_i,
   input  logic [DATA_W-1:0]   data_wdata_i,
   output logic [DATA_W-1:0]   data_rdata_o,
   output logic                data_ack_o,
   output logic                busy_o,
   output logic [ADDR_W-1:0]   sram_addr_o,
   output logic                sram_ce_n_o,
   output logic                sram_oe_n_o,
   output logic                sram_we_n_o,
   output logic [DATA_W/8-1:0] sram_be_n_o,
   output logic [DATA_W-1:0]   sram_wdata_o,
   output logic                sram_data_oe_o,
   input  logic [DATA_W-1:0]   sram_rdata_i
);

   localparam int         BE_W     = DATA_W / 8;
   localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_t;

   state_t     state_reg;
   logic       sel_data_reg;   // 1: the access in flight belongs to the data master
   logic       we_reg;         // 1: the access in flight is a store
   logic [2:0] cnt_reg;        // remaining extra ACCESS cycles
   logic       rr_data_reg;    // 1: the next tie goes to the data master

   logic            grant_any;
   logic            grant_data;
   logic            grant_we;
   logic [BE_W-1:0] grant_be_n;

   // Arbitration: a lone requester wins; ties go to data or to the round-robin choice.
   always_comb begin
      grant_any  = inst_req_i | data_req_i;
      grant_data = data_req_i & (~inst_req_i | (DATA_PRIORITY != 0) | rr_data_reg);
      grant_we   = grant_data & data_we_i;
   end

   // Byte lanes: a store drives the inverted byte enables, any read enables every lane.
   generate
      for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_lane
         assign grant_be_n[gi] = grant_we ? ~data_be_i[gi] : 1'b0;
      end
   endgenerate

   assign busy_o = (state_reg != ST_IDLE);

   // Transfer sequencer with registered SRAM strobes, acks and read-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         sel_data_reg   <= 1'b0;
         we_reg         <= 1'b0;
         cnt_reg        <= 3'd0;
         rr_data_reg    <= 1'b0;
         sram_addr_o    <= '0;
         sram_wdata_o   <= '0;
         sram_ce_n_o    <= 1'b1;
         sram_oe_n_o    <= 1'b1;
         sram_we_n_o    <= 1'b1;
         sram_be_n_o    <= '1;
         sram_data_oe_o <= 1'b0;
         inst_ack_o     <= 1'b0;
         data_ack_o     <= 1'b0;
         inst_rdata_o   <= '0;
         data_rdata_o   <= '0;
      end else begin
         inst_ack_o <= 1'b0;
         data_ack_o <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               sram_ce_n_o    <= 1'b1;
               sram_oe_n_o    <= 1'b1;
               sram_we_n_o    <= 1'b1;
               sram_be_n_o    <= '1;
               sram_data_oe_o <= 1'b0;
               if (grant_any) begin
                  state_reg      <= ST_ACCESS;
                  sel_data_reg   <= grant_data;
                  we_reg         <= grant_we;
                  cnt_reg        <= CNT_INIT;
                  rr_data_reg    <= ~grant_data;
                  sram_addr_o    <= grant_data ? data_addr_i : inst_addr_i;
                  sram_ce_n_o    <= 1'b0;
                  sram_oe_n_o    <= grant_we;
                  sram_we_n_o    <= ~grant_we;
                  sram_be_n_o    <= grant_be_n;
                  sram_data_oe_o <= grant_we;
                  if (grant_we) begin
                     sram_wdata_o <= data_wdata_i;
                  end
               end
            end
            ST_ACCESS: begin
               if (cnt_reg == 3'd0) begin
                  state_reg   <= ST_ACK;
                  sram_oe_n_o <= 1'b1;
                  sram_we_n_o <= 1'b1;
                  sram_be_n_o <= '1;
                  // A store keeps the chip selected and the bus driven for hold time.
                  sram_ce_n_o <= ~we_reg;
                  if (sel_data_reg) begin
                     data_ack_o <= 1'b1;
                  end else begin
                     inst_ack_o <= 1'b1;
                  end
                  if (!we_reg) begin
                     if (sel_data_reg) begin
                        data_rdata_o <= sram_rdata_i;
                     end else begin
                        inst_rdata_o <= sram_rdata_i;
                     end
                  end
               end else begin
                  cnt_reg <= cnt_reg - 3'd1;
               end
            end
            ST_ACK: begin
               state_reg      <= ST_IDLE;
               sram_ce_n_o    <= 1'b1;
               sram_data_oe_o <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
